kbd_matrix_scanner: RTL and testbench
=====================================

KBD_MATRIX_SCANNER -- requirements
Module: kbd_matrix_scanner

Interface
REQ-001 SHALL have parameter NUM_COLS, default 10, number of matrix columns (2..2^COL_W).
REQ-002 SHALL have parameter NUM_ROWS, default 8, number of matrix rows (2..16); row 0 is the diode row.
REQ-003 SHALL have parameter COL_W, default 4, width of column counter/select.
REQ-004 SHALL have parameter ROW_W, default 3, width of row_select.
REQ-005 SHALL have parameter BREAK_HOLD, default 16, minimum reset_out_n low cycles after break release.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous active-high reset.
REQ-009 keys_down  input  NUM_COLS*NUM_ROWS  active-high key states, column c row r at bit c*NUM_ROWS+r.
REQ-010 break_pressed  input  1  Break key, active high.
REQ-011 row_select  input  ROW_W  row to test in direct mode.
REQ-012 column_select  input  COL_W  column to test in direct mode.
REQ-013 keyboard_enable_n  input  1  low = direct mode, high = free-run scan.
REQ-014 irq_clear  input  1  clears key_irq.
REQ-015 selected_key_pressed  output  1  selected key down (direct mode only).
REQ-016 key_in_column_pressed  output  1  any row 1..NUM_ROWS-1 key down in current column.
REQ-017 key_irq  output  1  sticky free-run key detect.
REQ-018 reset_out_n  output  1  active-low system reset from Break.
REQ-019 scan_column  output  COL_W  current column counter.

Function
REQ-020 keys_down SHALL be registered every cycle; all decode SHALL use the registered copy (1-cycle input latency).
REQ-021 Direct mode: column register SHALL load column_select each cycle; decode SHALL use column_select combinationally.
REQ-022 Free-run: column register SHALL increment by 1 per cycle, wrapping 2^COL_W-1 -> 0; decode SHALL use the register.
REQ-023 Column values >= NUM_COLS SHALL decode as no keys pressed.
REQ-024 key_in_column_pressed SHALL be OR of rows 1..NUM_ROWS-1 of the decoded column, combinational, both modes.
REQ-025 selected_key_pressed SHALL be decoded[row_select] when keyboard_enable_n low, else 0; row_select >= NUM_ROWS SHALL give 0.
REQ-026 key_irq SHALL set on the cycle after key_in_column_pressed is high in free-run mode; irq_clear SHALL clear it; simultaneous set and clear SHALL leave it set.
REQ-027 Break FSM states IDLE, HELD, STRETCH: IDLE->HELD on registered break_pressed; HELD->STRETCH on release, loading counter BREAK_HOLD-1; STRETCH->IDLE when counter 0; STRETCH->HELD on re-press.
REQ-028 reset_out_n SHALL be 0 in HELD and STRETCH, 1 in IDLE (registered, no combinational path from break_pressed).

Reset
REQ-029 Reset SHALL clear key register, column (0), key_irq (0), FSM to IDLE; reset_out_n SHALL be 1 during and after reset.
REQ-030 Reset asserted mid-stretch SHALL abort to IDLE immediately.

Configuration
REQ-031 With KBD_MATRIX_GHOST_EN defined, decoded column c SHALL be keys[c] OR keys[c'] for every column c' sharing a pressed key in rows 1..NUM_ROWS-1 with c (single level, row 0 never bleeds).
REQ-032 Without KBD_MATRIX_GHOST_EN, decoded column SHALL be keys[c] only, no ghost logic synthesised.

Structure
REQ-033 Break FSM state encoding and default parameter constants SHALL live in shared package kbd_matrix_pkg.
REQ-034 Break FSM with stretch counter SHALL be sub-module kbd_break_stretch.

Verification
REQ-035 Direct mode, col 3 row 4 down (F) -> column_select=3, row_select=4 gives selected_key_pressed=1, key_in_column_pressed=1.
REQ-036 Free-run, only col 0 row 0 (Shift) down -> key_in_column_pressed never 1, key_irq stays 0, scan_column wraps 15->0.
REQ-037 Free-run, col 5 row 2 down -> key_irq set one cycle after scan_column=5; irq_clear same cycle as re-detect -> remains 1.
REQ-038 Break 3 cycles, BREAK_HOLD=16 -> reset_out_n low 3+16 cycles (plus 1 input register cycle), then 1.
REQ-039 KBD_MATRIX_GHOST_EN: col1 row5, col4 row5, col4 row7 down -> column_select=1,row_select=7 gives 1; without macro gives 0.
REQ-040 Reset asserted during STRETCH -> reset_out_n 1, scan_column 0 immediately.

Source files
------------

// File: rtl/kbd_matrix_pkg.sv
// Shared definitions for the keyboard matrix scanner.
// Holds the default parameter constants and the Break FSM state encoding.
package kbd_matrix_pkg;

    localparam int unsigned DefNumCols   = 10;
    localparam int unsigned DefNumRows   = 8;
    localparam int unsigned DefColW      = 4;
    localparam int unsigned DefRowW      = 3;
    localparam int unsigned DefBreakHold = 16;

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StStretch
    } break_state_e;

endpackage

// File: rtl/kbd_break_stretch.sv
// Break key reset stretcher.
// Holds reset_out_n low while Break is held and for BREAK_HOLD cycles after release.
// Ports:
//   clk          sole clock
//   reset        asynchronous active-high reset
//   break_q      registered Break key state
//   reset_out_n  active-low system reset, low in HELD and STRETCH
module kbd_break_stretch
    import kbd_matrix_pkg::*;
#(
    parameter int unsigned BREAK_HOLD = DefBreakHold
) (
    input  logic clk,
    input  logic reset,
    input  logic break_q,
    output logic reset_out_n
);

    localparam int unsigned CntW = (BREAK_HOLD > 2) ? $clog2(BREAK_HOLD) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(BREAK_HOLD - 1);

    break_state_e      state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (break_q) state_d = StHeld;
            end
            StHeld: begin
                if (!break_q) begin
                    state_d = StStretch;
                    cnt_d   = CntLoad;
                end
            end
            StStretch: begin
                if (break_q) begin
                    state_d = StHeld;
                end else if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Driven straight from the state register, so Break has no combinational path here.
    assign reset_out_n = (state_q == StIdle);

endmodule

// File: rtl/kbd_matrix_scanner.sv
// Keyboard matrix scanner with direct key test, free-run scan interrupt and Break reset.
// Optional build macro KBD_MATRIX_GHOST_EN models single-level matrix ghosting.
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   keys_down               key states, column c row r at bit c*NUM_ROWS+r
//   break_pressed           Break key
//   row_select              row tested in direct mode
//   column_select           column tested in direct mode
//   keyboard_enable_n       low = direct mode, high = free-run scan
//   irq_clear               clears key_irq
//   selected_key_pressed    selected key down (direct mode only)
//   key_in_column_pressed   any row 1..NUM_ROWS-1 down in decoded column
//   key_irq                 sticky free-run key detect
//   reset_out_n             active-low system reset from Break
//   scan_column             column counter
module kbd_matrix_scanner
    import kbd_matrix_pkg::*;
#(
    parameter int unsigned NUM_COLS   = DefNumCols,
    parameter int unsigned NUM_ROWS   = DefNumRows,
    parameter int unsigned COL_W      = DefColW,
    parameter int unsigned ROW_W      = DefRowW,
    parameter int unsigned BREAK_HOLD = DefBreakHold
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_COLS*NUM_ROWS-1:0] keys_down,
    input  logic                         break_pressed,
    input  logic [ROW_W-1:0]             row_select,
    input  logic [COL_W-1:0]             column_select,
    input  logic                         keyboard_enable_n,
    input  logic                         irq_clear,
    output logic                         selected_key_pressed,
    output logic                         key_in_column_pressed,
    output logic                         key_irq,
    output logic                         reset_out_n,
    output logic [COL_W-1:0]             scan_column
);

    logic [NUM_COLS*NUM_ROWS-1:0] keys_q;
    logic                         break_q;
    logic [COL_W-1:0]             col_q, col_d;
    logic                         irq_q, irq_d;
    logic [COL_W-1:0]             dec_col;
    logic [NUM_ROWS-1:0]          raw_bits;
    logic [NUM_ROWS-1:0]          dec_bits;
    logic                         sel_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_q  <= '0;
            break_q <= 1'b0;
            col_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            keys_q  <= keys_down;
            break_q <= break_pressed;
            col_q   <= col_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        col_d = keyboard_enable_n ? col_q + COL_W'(1) : column_select;
    end

    // Direct mode decodes the live select so the answer appears without a register stage.
    always_comb begin
        dec_col  = keyboard_enable_n ? col_q : column_select;
        raw_bits = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (dec_col == COL_W'(c)) raw_bits = keys_q[c*NUM_ROWS +: NUM_ROWS];
        end
    end

`ifdef KBD_MATRIX_GHOST_EN
    // Row 0 has diodes: it neither links columns nor receives ghosted keys.
    localparam logic [NUM_ROWS-1:0] RowMask = ~(NUM_ROWS'(1));

    always_comb begin
        dec_bits = raw_bits;
        for (int c = 0; c < NUM_COLS; c++) begin
            if ((keys_q[c*NUM_ROWS +: NUM_ROWS] & raw_bits & RowMask) != '0) begin
                dec_bits = dec_bits | (keys_q[c*NUM_ROWS +: NUM_ROWS] & RowMask);
            end
        end
    end
`else
    always_comb begin
        dec_bits = raw_bits;
    end
`endif

    always_comb begin
        sel_bit = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_select == ROW_W'(r)) sel_bit = dec_bits[r];
        end
    end

    always_comb begin
        key_in_column_pressed = |dec_bits[NUM_ROWS-1:1];
        selected_key_pressed  = ~keyboard_enable_n & sel_bit;
    end

    // Set wins over clear so a detect in the clearing cycle is not lost.
    always_comb begin
        irq_d = irq_q;
        if (irq_clear) irq_d = 1'b0;
        if (keyboard_enable_n && key_in_column_pressed) irq_d = 1'b1;
    end

    assign key_irq     = irq_q;
    assign scan_column = col_q;

    kbd_break_stretch #(
        .BREAK_HOLD (BREAK_HOLD)
    ) u_break_stretch (
        .clk         (clk),
        .reset       (reset),
        .break_q     (break_q),
        .reset_out_n (reset_out_n)
    );

endmodule

// File: tb/tb_kbd_matrix_scanner.sv
module tb_kbd_matrix_scanner;

    localparam int NC = 10;
    localparam int NR = 8;
    localparam int NK = NC * NR;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_down;
    logic          break_pressed;
    logic [2:0]    row_select;
    logic [3:0]    column_select;
    logic          keyboard_enable_n;
    logic          irq_clear;
    logic          selected_key_pressed;
    logic          key_in_column_pressed;
    logic          key_irq;
    logic          reset_out_n;
    logic [3:0]    scan_column;

    int checks   = 0;
    int failures = 0;

    kbd_matrix_scanner dut (
        .clk                   (clk),
        .reset                 (reset),
        .keys_down             (keys_down),
        .break_pressed         (break_pressed),
        .row_select            (row_select),
        .column_select         (column_select),
        .keyboard_enable_n     (keyboard_enable_n),
        .irq_clear             (irq_clear),
        .selected_key_pressed  (selected_key_pressed),
        .key_in_column_pressed (key_in_column_pressed),
        .key_irq               (key_irq),
        .reset_out_n           (reset_out_n),
        .scan_column           (scan_column)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NK-1:0] keys;
        logic [3:0]    col;
        logic [2:0]    row;
        logic          exp_sel;
        logic          exp_kic;
    } vec_t;

    typedef struct {
        logic sel;
        logic kic;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    function automatic logic [NK-1:0] key(input int c, input int r);
        logic [NK-1:0] k;
        k = '0;
        k[c*NR+r] = 1'b1;
        return k;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t          e;
        int            exp_col;
        logic          wrapped;
        logic          found;
        int            low_cnt;
        logic          ghost_exp;

`ifdef KBD_MATRIX_GHOST_EN
        ghost_exp = 1'b1;
`else
        ghost_exp = 1'b0;
`endif
        vecs[0] = '{key(3,4), 4'd3, 3'd4, 1'b1, 1'b1};
        vecs[1] = '{key(3,4), 4'd3, 3'd3, 1'b0, 1'b1};
        vecs[2] = '{key(3,4), 4'd2, 3'd4, 1'b0, 1'b0};
        vecs[3] = '{key(0,0), 4'd0, 3'd0, 1'b1, 1'b0};
        vecs[4] = '{key(9,7), 4'd9, 3'd7, 1'b1, 1'b1};
        vecs[5] = '{{NK{1'b1}}, 4'd12, 3'd1, 1'b0, 1'b0};
        vecs[6] = '{{NK{1'b1}}, 4'd10, 3'd0, 1'b0, 1'b0};
        vecs[7] = '{{NK{1'b1}}, 4'd9, 3'd0, 1'b1, 1'b1};
        vecs[8] = '{'0, 4'd3, 3'd4, 1'b0, 1'b0};
        vecs[9] = '{key(1,5) | key(4,5) | key(4,7), 4'd1, 3'd7, ghost_exp, 1'b1};

        reset = 1'b1;
        keys_down = '0;
        break_pressed = 1'b0;
        row_select = '0;
        column_select = '0;
        keyboard_enable_n = 1'b0;
        irq_clear = 1'b0;
        #12;
        check("reset_out_n_in_reset", 32'(reset_out_n), 1);
        check("scan_column_in_reset", 32'(scan_column), 0);
        check("key_irq_in_reset", 32'(key_irq), 0);
        check("sel_in_reset", 32'(selected_key_pressed), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("reset_out_n_after_reset", 32'(reset_out_n), 1);

        // Direct-mode table
        for (int i = 0; i < 10; i++) begin
            keys_down = vecs[i].keys;
            column_select = vecs[i].col;
            row_select = vecs[i].row;
            sb.push_back('{vecs[i].exp_sel, vecs[i].exp_kic});
            tick();
            e = sb.pop_front();
            check($sformatf("vec%0d_sel", i), 32'(selected_key_pressed), 32'(e.sel));
            check($sformatf("vec%0d_kic", i), 32'(key_in_column_pressed), 32'(e.kic));
            check($sformatf("vec%0d_irq", i), 32'(key_irq), 0);
        end

        // Free-run with only Shift down: no detect, counter wraps
        keys_down = key(0,0);
        column_select = 4'd0;
        tick();
        keyboard_enable_n = 1'b1;
        exp_col = 0;
        wrapped = 1'b0;
        check("fr_start_col", 32'(scan_column), 0);
        check("fr_sel_zero", 32'(selected_key_pressed), 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            exp_col = (exp_col + 1) % 16;
            if (exp_col == 0 && scan_column == 4'd0) wrapped = 1'b1;
            check("fr_col", 32'(scan_column), 32'(exp_col));
            check("fr_shift_kic", 32'(key_in_column_pressed), 0);
            check("fr_shift_irq", 32'(key_irq), 0);
        end
        check("fr_wrapped", 32'(wrapped), 1);

        // Free-run with col 5 row 2: irq timing and set-over-clear
        keys_down = key(5,2);
        tick();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (scan_column == 4'd5) found = 1'b1;
        end
        check("irq_col5_found", 32'(found), 1);
        check("irq_kic_at_5", 32'(key_in_column_pressed), 1);
        check("irq_not_yet", 32'(key_irq), 0);
        tick();
        check("irq_set", 32'(key_irq), 1);
        check("irq_col6", 32'(scan_column), 6);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check("irq_cleared", 32'(key_irq), 0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (scan_column == 4'd5) found = 1'b1;
        end
        check("irq_col5_again", 32'(found), 1);
        check("irq_stays_clear", 32'(key_irq), 0);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check("irq_set_beats_clear", 32'(key_irq), 1);

        // Break held 3 cycles: low for 3+16 sampled cycles
        keyboard_enable_n = 1'b0;
        keys_down = '0;
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        tick();
        check("brk_idle", 32'(reset_out_n), 1);
        break_pressed = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 2) break_pressed = 1'b0;
            if (!reset_out_n) low_cnt++;
        end
        check("brk_low_cycles", 32'(low_cnt), 19);
        check("brk_released", 32'(reset_out_n), 1);

        // Re-press during stretch returns to HELD
        break_pressed = 1'b1;
        tick();
        break_pressed = 1'b0;
        repeat (6) tick();
        check("brk_stretch_low", 32'(reset_out_n), 0);
        break_pressed = 1'b1;
        repeat (12) tick();
        check("brk_repress_held", 32'(reset_out_n), 0);
        break_pressed = 1'b0;
        repeat (6) tick();
        check("brk_stretch2_low", 32'(reset_out_n), 0);

        // Async reset mid-stretch, free-running so column is non-zero
        keyboard_enable_n = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_stretch_rout", 32'(reset_out_n), 1);
        check("rst_mid_stretch_col", 32'(scan_column), 0);
        @(negedge clk);
        reset = 1'b0;
        keyboard_enable_n = 1'b0;
        repeat (3) tick();
        check("rst_after_rout", 32'(reset_out_n), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
